ysyx_pc_redirect_ctrl: RTL
==========================

# ysyx_pc_redirect_ctrl

Front-end redirect controller between the redirect sources (trap unit, commit-time mispredict, `fence.i` retire, EXU jump) and the fetch PC register. It picks one redirect per sequence by fixed priority, flushes the pipeline, holds for a configurable drain period, then hands the new PC to the IFU with a valid/ready handshake. Out of reset it issues a boot redirect to `PC_INIT`.

## Interface

Parameters:
- `XLEN`, default 32: PC width.
- `PC_INIT`, default `32'h8000_0000`: boot redirect target.
- `FLUSH_CYCLES`, default 2: drain cycles after a flush; legal range 1..15.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `trap_valid` / `trap_target`  input  1 / XLEN: trap or `mret` redirect; priority 3, highest.
- `mispred_valid` / `mispred_target`  input  1 / XLEN: commit-time bad speculation; priority 2.
- `fence_valid` / `fence_pc`  input  1 / XLEN: `fence.i` retired at `fence_pc`; priority 1.
- `exu_valid` / `exu_target`  input  1 / XLEN: EXU jump/branch redirect; priority 0.
- `ifu_ready`  input  1: IFU accepts `redir_pc` this cycle.
- `redir_valid`  output  1: `redir_pc` is valid.
- `redir_pc`  output  XLEN: redirect target.
- `flush_o`  output  1: one-cycle pipeline flush pulse.
- `busy_o`  output  1: sequence in progress; upstream fetch stalls.
- `redir_cnt`  output  32: completed redirect handshakes, wraps at 2^32.

## Operation

- States: IDLE, FLUSH, ISSUE. `busy_o` = state != IDLE.
- Target formation:
  - fence target = `fence_pc + 4`, modulo 2^XLEN.
  - All targets have bit 0 forced to 0.
  - The latched target and its priority are held in `cur_pc` / `cur_pri`.
- IDLE:
  - No request: stay IDLE.
  - Any request: latch the highest-priority valid source, reload the drain counter with `FLUSH_CYCLES`, go to FLUSH.
- FLUSH:
  - Counter decrements each cycle.
  - When it reaches 0, go to ISSUE.
- ISSUE:
  - `redir_valid` = 1 and `redir_pc` = `cur_pc`, both stable until handshake.
  - Handshake (`redir_valid & ifu_ready`): `redir_cnt` += 1, go to IDLE.
- Preemption in FLUSH or ISSUE:
  - A request with priority strictly greater than `cur_pri` replaces `cur_pc` / `cur_pri`, reloads the counter, pulses `flush_o`, and goes to FLUSH.
  - Requests of equal or lower priority are dropped; they are younger than the flushed path.
- Simultaneous preemption and ISSUE handshake:
  - The handshake completes and is counted.
  - The new request starts a fresh sequence: FLUSH, `flush_o` pulse. It does not return to IDLE.
- Multiple simultaneous requests: only the highest priority is kept; the rest are dropped.
- Reset (async, any time, including mid-sequence):
  - State = ISSUE, `redir_valid` = 1, `redir_pc` = `PC_INIT`, `cur_pri` = 3.
  - `flush_o` = 0, `busy_o` = 1, `redir_cnt` = 0, counter = 0.
  - The boot handshake counts toward `redir_cnt`.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- A request sampled at edge t:
  - `flush_o` = 1 for exactly the cycle after t.
  - FLUSH occupies cycles t+1 .. t+`FLUSH_CYCLES`.
  - `redir_valid` rises at cycle t+`FLUSH_CYCLES`+1.
  - Minimum request-to-valid latency = `FLUSH_CYCLES` + 1 cycles.
- Handshake at edge h:
  - `redir_valid` = 0 and `redir_cnt` updated in the cycle after h.
  - A new IDLE request can be sampled at h+1 at the earliest, unless it preempted at h.
- `flush_o` is never high on two consecutive cycles unless consecutive strictly-increasing preemptions occur.
- `flush_o` is never high during reset or for the boot redirect.

## Test plan

- **Boot:** hold `rst`=0 for 3 cycles, release, `ifu_ready`=0 for 4 cycles then 1 → `redir_valid`=1 and `redir_pc`=`0x8000_0000` from release through the handshake; `redir_cnt` 0→1; `flush_o` never asserted.
- **Single EXU redirect:** `FLUSH_CYCLES`=2, `exu_target`=`0x8000_0103` at t, `ifu_ready`=1 → `flush_o` at t+1; `redir_valid` at t+3 with `redir_pc`=`0x8000_0102`; IDLE at t+4.
- **Simultaneous sources:** trap `0x8000_0200`, mispred `0x8000_0300` and exu valid at the same edge → only `redir_pc`=`0x8000_0200` is issued; exactly one handshake.
- **Preemption and drop:** mispred `0x10` at t; exu at t+1 (dropped); trap `0x20` at t+2 → `flush_o` at t+1 and t+3; `redir_pc`=`0x20` at t+5; `redir_cnt` +1.
- **Fence wrap:** `fence_pc`=`0xFFFF_FFFC` → `redir_pc`=`0x0000_0000`. Separately, a trap arriving on the same edge as an ISSUE handshake → `redir_cnt` +1 and a new FLUSH begins.
- **Reset mid-sequence:** assert `rst`=0 during FLUSH → outputs return to boot values immediately, without waiting for a clock edge; the pending target is discarded.

Source files
------------

// File: rtl/ysyx_pc_redirect_ctrl_if.sv
// Redirect bundle between the redirect sources / IFU (master) and the
// PC redirect controller (slave).
interface ysyx_pc_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic            mispred_valid;
    logic [XLEN-1:0] mispred_target;
    logic            fence_valid;
    logic [XLEN-1:0] fence_pc;
    logic            exu_valid;
    logic [XLEN-1:0] exu_target;
    logic            ifu_ready;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            flush_o;
    logic            busy_o;
    logic [31:0]     redir_cnt;

    modport master (
        output trap_valid, trap_target, mispred_valid, mispred_target,
               fence_valid, fence_pc, exu_valid, exu_target, ifu_ready,
        input  redir_valid, redir_pc, flush_o, busy_o, redir_cnt
    );

    modport slave (
        input  trap_valid, trap_target, mispred_valid, mispred_target,
               fence_valid, fence_pc, exu_valid, exu_target, ifu_ready,
        output redir_valid, redir_pc, flush_o, busy_o, redir_cnt
    );
endinterface

// File: rtl/ysyx_pc_redirect_ctrl.sv
// Front-end redirect controller: fixed-priority source select, flush, drain,
// then valid/ready hand-off of the new PC to the IFU. Boots into a PC_INIT issue.
module ysyx_pc_redirect_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] PC_INIT      = 32'h8000_0000,
    parameter int              FLUSH_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [XLEN-1:0] cur_pc_q, cur_pc_d;
    logic [1:0]      cur_pri_q, cur_pri_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic            redir_valid_q, redir_valid_d;
    logic            busy_q, busy_d;
    logic [31:0]     redir_cnt_q, redir_cnt_d;

    logic            req_any;
    logic [1:0]      req_pri;
    logic [XLEN-1:0] req_raw;
    logic [XLEN-1:0] req_pc;
    logic            handshake;
    logic            take_req;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        req_any = bus.trap_valid | bus.mispred_valid | bus.fence_valid | bus.exu_valid;
        req_pri = 2'd0;
        req_raw = bus.exu_target;
        if (bus.trap_valid) begin
            req_pri = 2'd3;
            req_raw = bus.trap_target;
        end else if (bus.mispred_valid) begin
            req_pri = 2'd2;
            req_raw = bus.mispred_target;
        end else if (bus.fence_valid) begin
            req_pri = 2'd1;
            req_raw = bus.fence_pc + XLEN'(4);
        end
        req_pc = {req_raw[XLEN-1:1], 1'b0};
    end

    assign handshake = redir_valid_q & bus.ifu_ready;
    // Anything wins from IDLE; mid-sequence only a strictly older source may flush again.
    assign take_req  = req_any && ((state_q == IDLE) || (req_pri > cur_pri_q));

    always_comb begin
        state_d     = state_q;
        cur_pc_d    = cur_pc_q;
        cur_pri_d   = cur_pri_q;
        cnt_d       = cnt_q;
        flush_d     = 1'b0;
        redir_cnt_d = redir_cnt_q + 32'(handshake);

        if (take_req) begin
            state_d   = FLUSH;
            cur_pc_d  = req_pc;
            cur_pri_d = req_pri;
            cnt_d     = FLUSH_LD;
            flush_d   = 1'b1;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ISSUE: begin
                    if (handshake) state_d = IDLE;
                end
                default: ;
            endcase
        end

        redir_valid_d = (state_d == ISSUE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q       <= ISSUE;
            cur_pc_q      <= PC_INIT;
            cur_pri_q     <= 2'd3;
            cnt_q         <= 4'd0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            redir_cnt_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            cur_pc_q      <= cur_pc_d;
            cur_pri_q     <= cur_pri_d;
            cnt_q         <= cnt_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            busy_q        <= busy_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = cur_pc_q;
    assign bus.flush_o     = flush_q;
    assign bus.busy_o      = busy_q;
    assign bus.redir_cnt   = redir_cnt_q;
endmodule
